mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares the single memory_controller request/return port pair between two requesters (r0, r1).
- Accepts at most one request (read or write) per cycle using round-robin arbitration.
- Records the requester of each outstanding read by address, because the controller tags returns by address, and routes each return to the requester that issued it.
- Sits directly in front of memory_controller. Its mc_* outputs drive the controller's wr_*/rd_* inputs; the controller's rd_ret_* outputs feed its mc_rd_ret_* inputs.

## Interface

Parameters:

- AW, 16: address width
- DW, 16: data width
- N_OUT, 4: read tag table depth (maximum outstanding reads, both requesters combined)

Ports (for each k in {0,1}, all rk_* lines exist):

- clk  in  1  clock; the only clock in the block
- reset  in  1  synchronous, active-high reset
- rk_valid  in  1  request valid; held until accepted
- rk_we  in  1  1 = write, 0 = read
- rk_addr  in  AW  request address
- rk_wdata  in  DW  write data; ignored for reads
- rk_ready  out  1  combinational grant; the request is accepted on any edge where rk_valid && rk_ready
- rk_rd_valid  out  1  one-cycle read-return pulse
- rk_rd_addr  out  AW  address of the returned read
- rk_rd_data  out  DW  returned data
- mc_wr_en  out  1  write issue pulse
- mc_wr_address  out  AW  write address
- mc_wr_data  out  DW  write data
- mc_rd_en  out  1  read issue pulse
- mc_rd_address  out  AW  read address
- mc_rd_ret_ack  in  1  controller return valid
- mc_rd_ret_address  in  AW  return tag (equals the read address)
- mc_rd_ret_data  in  DW  return data
- outstanding  out  $clog2(N_OUT+1)  number of valid table entries
- orphan_ret  out  1  sticky flag: a return matched no table entry

The controller's write return is not used. Writes are fire-and-forget.

## Operation

Eligibility:

- A request is eligible when rk_valid is high and it is not blocked.
- A read is blocked when the table is full, or when rk_addr matches a valid table entry.
- A write is blocked when rk_addr matches a valid table entry (avoids read/write hazards to the same address).
- Blocking, full and match are computed from registered table state only. An entry freed in the current cycle cannot be reused, or stop blocking, until the next cycle.

Arbitration:

- Round-robin over eligible requesters. A 1-bit pointer rr names the priority requester.
- If both are eligible, grant rr. If only one is eligible, grant that one.
- After any grant, rr becomes the non-granted index. rr is unchanged when nothing is granted.

On acceptance:

- Write: register mc_wr_en=1, mc_wr_address, mc_wr_data.
- Read: register mc_rd_en=1 and mc_rd_address. Allocate the lowest-index free table entry with {valid=1, addr, id=k}.

Returns:

- When mc_rd_ret_ack=1, compare mc_rd_ret_address against all valid entries. At most one entry can match, because duplicates are blocked at issue.
- Hit: clear the entry and register r{id}_rd_valid=1 with the return address and data.
- Miss: drop the data and set orphan_ret.

outstanding:

- Increments on each read grant and decrements on each return hit.
- When both occur in the same cycle, the net change is 0.

## Timing

- Reset values: every output is 0. The table is cleared, rr=0, outstanding=0, orphan_ret=0.
- Reset mid-operation discards all table entries. A return arriving after reset for a discarded read sets orphan_ret.
- rk_ready is combinational in the same cycle; all other outputs are registered.
- Issue latency: a request accepted at edge t drives mc_*_en high during cycle t+1, for exactly one cycle. With no accept, the enables are 0 in the next cycle.
- Return latency: mc_rd_ret_ack sampled at edge t drives rk_rd_valid high during cycle t+1, for one cycle.
- Return path and issue path are independent. Both may be active in the same cycle.
- A return to address X and a new read to X in the same cycle: the read stays blocked that cycle and is accepted the following cycle.
- Table full (outstanding == N_OUT): all reads are blocked; writes to non-matching addresses still proceed.

## Structure

- Package mem_arb_pkg holds:
  - the AW/DW defaults;
  - the requester id type (1 bit);
  - the tag entry struct {valid, addr, id}.
- Sub-module rd_tag_table: N_OUT-entry associative table. It provides:
  - allocate (lowest free entry);
  - lookup/free on return;
  - issue-address match;
  - full flag and count.
- The top level holds the round-robin arbiter, the issue registers and the return registers.

## Test plan

- Reads to 0x0010 from r0 only; controller returns 0x0010/0xBEEF three cycles later → r0_rd_valid pulses with data 0xBEEF; r1_rd_valid stays 0; outstanding goes 1→0.
- r0 and r1 both hold valid reads (0x0100, 0x0200) continuously from reset → grants alternate r0, r1, r0, …; exactly one mc_rd_en per cycle; first grant goes to r0.
- Five reads with no returns → fourth accepted; fifth read held with r_ready=0; a concurrent write to 0x0300 is still issued; one return frees a slot and the fifth read issues the cycle after.
- r1 read of 0x0040 is outstanding; r0 then issues a read and a write to 0x0040 → both blocked until the return; return is routed to r1 only.
- Return with mc_rd_ret_address=0x7777 that matches nothing → orphan_ret=1 and stays set; no rk_rd_valid pulses; reset clears it.
- Reset asserted with two reads outstanding → all outputs 0 and outstanding=0 the next cycle; a later return for either read sets orphan_ret.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  // Identifies which requester (r0 or r1) issued a read.
  typedef logic req_id_t;

  // One read-tag table slot: the controller tags returns by address, so the
  // address is the lookup key and id says where the data goes back to.
  typedef struct packed {
    logic                valid;
    logic [AW_DEF-1:0]   addr;
    req_id_t             id;
  } tag_entry_t;

endpackage

// File: rtl/rd_tag_table.sv
// Associative table of outstanding reads, keyed by address.
// All lookups use registered state only, so a slot freed this cycle is
// neither reusable nor non-blocking until the next cycle.
module rd_tag_table
  import mem_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int N_OUT = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_i,
  input  logic [AW-1:0] alloc_addr_i,
  input  req_id_t       alloc_id_i,
  input  logic [AW-1:0] chk0_addr_i,
  input  logic [AW-1:0] chk1_addr_i,
  output logic          chk0_match_o,
  output logic          chk1_match_o,
  input  logic          ret_i,
  input  logic [AW-1:0] ret_addr_i,
  output logic          ret_hit_o,
  output req_id_t       ret_id_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  tag_entry_t       entries_q [N_OUT];
  tag_entry_t       entries_d [N_OUT];
  logic [CW-1:0]    count_q, count_d;
  logic [N_OUT-1:0] free_oh;
  logic [N_OUT-1:0] hit_oh;
  logic             free_found;

  // Match both issue addresses and the return tag; pick the lowest free slot.
  always_comb begin
    chk0_match_o = 1'b0;
    chk1_match_o = 1'b0;
    ret_hit_o    = 1'b0;
    ret_id_o     = 1'b0;
    free_oh      = '0;
    hit_oh       = '0;
    free_found   = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (entries_q[i].valid) begin
        if (entries_q[i].addr == AW_DEF'(chk0_addr_i)) chk0_match_o = 1'b1;
        else chk0_match_o = chk0_match_o;
        if (entries_q[i].addr == AW_DEF'(chk1_addr_i)) chk1_match_o = 1'b1;
        else chk1_match_o = chk1_match_o;
        if (ret_i && (entries_q[i].addr == AW_DEF'(ret_addr_i))) begin
          ret_hit_o = 1'b1;
          ret_id_o  = entries_q[i].id;
          hit_oh[i] = 1'b1;
        end else begin
          hit_oh[i] = 1'b0;
        end
      end else if (!free_found) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
      end else begin
        free_oh[i] = 1'b0;
      end
    end
  end

  // Next table contents and occupancy count from the allocate/free events.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      entries_d[i] = entries_q[i];
      if (alloc_i && free_oh[i]) begin
        entries_d[i].valid = 1'b1;
        entries_d[i].addr  = AW_DEF'(alloc_addr_i);
        entries_d[i].id    = alloc_id_i;
      end else if (hit_oh[i]) begin
        entries_d[i].valid = 1'b0;
      end else begin
        entries_d[i] = entries_q[i];
      end
    end
    case ({alloc_i, ret_hit_o})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Table and count state register; reset discards every outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) entries_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) entries_q[i] <= entries_d[i];
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == CW'(N_OUT));
  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_controller port between r0 and r1,
// routing read returns back to the issuing requester by address tag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int N_OUT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       r0_valid,
  input  logic                       r0_we,
  input  logic [AW-1:0]              r0_addr,
  input  logic [DW-1:0]              r0_wdata,
  output logic                       r0_ready,
  output logic                       r0_rd_valid,
  output logic [AW-1:0]              r0_rd_addr,
  output logic [DW-1:0]              r0_rd_data,
  input  logic                       r1_valid,
  input  logic                       r1_we,
  input  logic [AW-1:0]              r1_addr,
  input  logic [DW-1:0]              r1_wdata,
  output logic                       r1_ready,
  output logic                       r1_rd_valid,
  output logic [AW-1:0]              r1_rd_addr,
  output logic [DW-1:0]              r1_rd_data,
  output logic                       mc_wr_en,
  output logic [AW-1:0]              mc_wr_address,
  output logic [DW-1:0]              mc_wr_data,
  output logic                       mc_rd_en,
  output logic [AW-1:0]              mc_rd_address,
  input  logic                       mc_rd_ret_ack,
  input  logic [AW-1:0]              mc_rd_ret_address,
  input  logic [DW-1:0]              mc_rd_ret_data,
  output logic [$clog2(N_OUT+1)-1:0] outstanding,
  output logic                       orphan_ret
);

  localparam int CW = $clog2(N_OUT+1);

  logic          match0, match1, full, ret_hit;
  req_id_t       ret_id;
  logic          elig0, elig1, grant_any, sel_we, alloc;
  req_id_t       grant_id;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rr_q, rr_d;
  logic          mc_wr_en_q, mc_rd_en_q;
  logic [AW-1:0] mc_wr_address_q, mc_rd_address_q;
  logic [DW-1:0] mc_wr_data_q;
  logic          r0_rd_valid_q, r1_rd_valid_q, orphan_q;
  logic [AW-1:0] r0_rd_addr_q, r1_rd_addr_q;
  logic [DW-1:0] r0_rd_data_q, r1_rd_data_q;

  rd_tag_table #(.AW(AW), .N_OUT(N_OUT), .CW(CW)) u_tags (
    .clk          (clk),
    .reset        (reset),
    .alloc_i      (alloc),
    .alloc_addr_i (sel_addr),
    .alloc_id_i   (grant_id),
    .chk0_addr_i  (r0_addr),
    .chk1_addr_i  (r1_addr),
    .chk0_match_o (match0),
    .chk1_match_o (match1),
    .ret_i        (mc_rd_ret_ack),
    .ret_addr_i   (mc_rd_ret_address),
    .ret_hit_o    (ret_hit),
    .ret_id_o     (ret_id),
    .full_o       (full),
    .count_o      (outstanding)
  );

  // Eligibility and round-robin grant; writes are not limited by a full table.
  always_comb begin
    elig0     = r0_valid && !match0 && (r0_we || !full);
    elig1     = r1_valid && !match1 && (r1_we || !full);
    grant_any = elig0 || elig1;
    if (elig0 && elig1) grant_id = rr_q;
    else if (elig1)     grant_id = 1'b1;
    else                grant_id = 1'b0;
    sel_we    = grant_id ? r1_we    : r0_we;
    sel_addr  = grant_id ? r1_addr  : r0_addr;
    sel_wdata = grant_id ? r1_wdata : r0_wdata;
    alloc     = grant_any && !sel_we;
    rr_d      = grant_any ? ~grant_id : rr_q;
  end

  assign r0_ready = grant_any && (grant_id == 1'b0);
  assign r1_ready = grant_any && (grant_id == 1'b1);

  // Issue registers: one-cycle enable pulses, address/data held between issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q            <= 1'b0;
      mc_wr_en_q      <= 1'b0;
      mc_rd_en_q      <= 1'b0;
      mc_wr_address_q <= '0;
      mc_wr_data_q    <= '0;
      mc_rd_address_q <= '0;
    end else begin
      rr_q       <= rr_d;
      mc_wr_en_q <= grant_any && sel_we;
      mc_rd_en_q <= alloc;
      if (grant_any && sel_we) begin
        mc_wr_address_q <= sel_addr;
        mc_wr_data_q    <= sel_wdata;
      end
      if (alloc) mc_rd_address_q <= sel_addr;
    end
  end

  // Return registers: route a tag hit to its requester, flag unmatched returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r0_rd_valid_q <= 1'b0;
      r1_rd_valid_q <= 1'b0;
      r0_rd_addr_q  <= '0;
      r0_rd_data_q  <= '0;
      r1_rd_addr_q  <= '0;
      r1_rd_data_q  <= '0;
      orphan_q      <= 1'b0;
    end else begin
      r0_rd_valid_q <= ret_hit && (ret_id == 1'b0);
      r1_rd_valid_q <= ret_hit && (ret_id == 1'b1);
      if (ret_hit && (ret_id == 1'b0)) begin
        r0_rd_addr_q <= mc_rd_ret_address;
        r0_rd_data_q <= mc_rd_ret_data;
      end
      if (ret_hit && (ret_id == 1'b1)) begin
        r1_rd_addr_q <= mc_rd_ret_address;
        r1_rd_data_q <= mc_rd_ret_data;
      end
      orphan_q <= orphan_q || (mc_rd_ret_ack && !ret_hit);
    end
  end

  assign mc_wr_en      = mc_wr_en_q;
  assign mc_wr_address = mc_wr_address_q;
  assign mc_wr_data    = mc_wr_data_q;
  assign mc_rd_en      = mc_rd_en_q;
  assign mc_rd_address = mc_rd_address_q;
  assign r0_rd_valid   = r0_rd_valid_q;
  assign r0_rd_addr    = r0_rd_addr_q;
  assign r0_rd_data    = r0_rd_data_q;
  assign r1_rd_valid   = r1_rd_valid_q;
  assign r1_rd_addr    = r1_rd_addr_q;
  assign r1_rd_data    = r1_rd_data_q;
  assign orphan_ret    = orphan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_mem_arbiter;

  localparam int N_OUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        r0_valid = 1'b0, r0_we = 1'b0, r1_valid = 1'b0, r1_we = 1'b0;
  logic [15:0] r0_addr = 16'h0, r0_wdata = 16'h0, r1_addr = 16'h0, r1_wdata = 16'h0;
  logic        r0_ready, r1_ready, r0_rd_valid, r1_rd_valid;
  logic [15:0] r0_rd_addr, r0_rd_data, r1_rd_addr, r1_rd_data;
  logic        mc_wr_en, mc_rd_en;
  logic [15:0] mc_wr_address, mc_wr_data, mc_rd_address;
  logic        mc_rd_ret_ack = 1'b0;
  logic [15:0] mc_rd_ret_address = 16'h0, mc_rd_ret_data = 16'h0;
  logic [2:0]  outstanding;
  logic        orphan_ret;

  mem_arbiter #(.AW(16), .DW(16), .N_OUT(N_OUT)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rd_valid(r0_rd_valid), .r0_rd_addr(r0_rd_addr), .r0_rd_data(r0_rd_data),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rd_valid(r1_rd_valid), .r1_rd_addr(r1_rd_addr), .r1_rd_data(r1_rd_data),
    .mc_wr_en(mc_wr_en), .mc_wr_address(mc_wr_address), .mc_wr_data(mc_wr_data),
    .mc_rd_en(mc_rd_en), .mc_rd_address(mc_rd_address),
    .mc_rd_ret_ack(mc_rd_ret_ack), .mc_rd_ret_address(mc_rd_ret_address), .mc_rd_ret_data(mc_rd_ret_data),
    .outstanding(outstanding), .orphan_ret(orphan_ret)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: outstanding reads as an ordered list of (address, requester).
  logic [15:0] m_addr[$];
  logic        m_id[$];
  logic        m_rr;
  logic        m_orph;

  logic cap_rdy0, cap_rdy1, cap_wr, cap_rd, cap_rv0, cap_rv1, cap_orph;
  int   cap_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_match(input logic [15:0] a);
    foreach (m_addr[i]) if (m_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 16'h0; r0_wdata = 16'h0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 16'h0; r1_wdata = 16'h0;
    mc_rd_ret_ack = 1'b0; mc_rd_ret_address = 16'h0; mc_rd_ret_data = 16'h0;
    @(posedge clk); #1;
    m_addr.delete(); m_id.delete(); m_rr = 1'b0; m_orph = 1'b0;
    chk("rst_r0_ready", r0_ready, 0);       chk("rst_r1_ready", r1_ready, 0);
    chk("rst_mc_wr_en", mc_wr_en, 0);       chk("rst_mc_rd_en", mc_rd_en, 0);
    chk("rst_mc_wr_address", mc_wr_address, 0); chk("rst_mc_wr_data", mc_wr_data, 0);
    chk("rst_mc_rd_address", mc_rd_address, 0);
    chk("rst_r0_rd_valid", r0_rd_valid, 0); chk("rst_r1_rd_valid", r1_rd_valid, 0);
    chk("rst_r0_rd_addr", r0_rd_addr, 0);   chk("rst_r0_rd_data", r0_rd_data, 0);
    chk("rst_r1_rd_addr", r1_rd_addr, 0);   chk("rst_r1_rd_data", r1_rd_data, 0);
    chk("rst_outstanding", outstanding, 0); chk("rst_orphan_ret", orphan_ret, 0);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the combinational grant, advance the
  // model across the edge and check every registered output.
  task automatic cyc(input logic v0, we0, input logic [15:0] a0, d0,
                     input logic v1, we1, input logic [15:0] a1, d1,
                     input logic ack, input logic [15:0] ra, rd);
    logic el0, el1, any, g, full, sw, e_wr, e_rd, e_rv0, e_rv1;
    int   hit;
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    mc_rd_ret_ack = ack; mc_rd_ret_address = ra; mc_rd_ret_data = rd;
    #1;
    full = (m_addr.size() == N_OUT);
    el0  = v0 && !m_match(a0) && (we0 || !full);
    el1  = v1 && !m_match(a1) && (we1 || !full);
    any  = el0 || el1;
    g    = (el0 && el1) ? m_rr : el1;
    chk("r0_ready", r0_ready, any && !g);
    chk("r1_ready", r1_ready, any && g);
    cap_rdy0 = r0_ready; cap_rdy1 = r1_ready;
    e_rv0 = 1'b0; e_rv1 = 1'b0; hit = -1;
    if (ack) begin
      foreach (m_addr[i]) if (hit < 0 && m_addr[i] == ra) hit = i;
      if (hit >= 0) begin
        if (m_id[hit]) e_rv1 = 1'b1; else e_rv0 = 1'b1;
        m_addr.delete(hit); m_id.delete(hit);
      end else m_orph = 1'b1;
    end
    sw   = g ? we1 : we0;
    e_wr = any && sw;
    e_rd = any && !sw;
    if (any) m_rr = ~g;
    if (e_rd) begin m_addr.push_back(g ? a1 : a0); m_id.push_back(g); end
    @(posedge clk); #1;
    chk("mc_wr_en", mc_wr_en, e_wr);
    if (e_wr) begin
      chk("mc_wr_address", mc_wr_address, g ? a1 : a0);
      chk("mc_wr_data", mc_wr_data, g ? d1 : d0);
    end
    chk("mc_rd_en", mc_rd_en, e_rd);
    if (e_rd) chk("mc_rd_address", mc_rd_address, g ? a1 : a0);
    chk("r0_rd_valid", r0_rd_valid, e_rv0);
    chk("r1_rd_valid", r1_rd_valid, e_rv1);
    if (e_rv0) begin chk("r0_rd_addr", r0_rd_addr, ra); chk("r0_rd_data", r0_rd_data, rd); end
    if (e_rv1) begin chk("r1_rd_addr", r1_rd_addr, ra); chk("r1_rd_data", r1_rd_data, rd); end
    chk("outstanding", outstanding, m_addr.size());
    chk("orphan_ret", orphan_ret, m_orph);
    cap_wr = mc_wr_en; cap_rd = mc_rd_en; cap_rv0 = r0_rd_valid; cap_rv1 = r1_rd_valid;
    cap_out = int'(outstanding); cap_orph = orphan_ret;
  endtask

  task automatic idle(input logic ack, input logic [15:0] ra, rd);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, ack, ra, rd);
  endtask

  typedef struct {
    bit rst; bit v0; bit we0; logic [15:0] a0; bit v1; bit we1; logic [15:0] a1;
    bit ack; logic [15:0] ra; logic [15:0] rd;
    bit x_rdy0; bit x_rdy1; bit x_wr; bit x_rd; bit x_rv0; bit x_rv1; int x_out;
  } vec_t;

  vec_t vt[14];

  logic        p_v[2], p_we[2];
  logic [15:0] p_a[2], p_d[2];

  initial begin
    // rst, v0,we0,a0, v1,we1,a1, ack,ra,rd, rdy0,rdy1,wr,rd,rv0,rv1,out
    vt[0]  = '{1'b1, 1'b0,1'b0,16'h0,   1'b0,1'b0,16'h0,   1'b0,16'h0,16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,0};
    vt[1]  = '{1'b0, 1'b1,1'b0,16'h0010,1'b0,1'b0,16'h0,   1'b0,16'h0,16'h0,    1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1};
    vt[2]  = '{1'b0, 1'b0,1'b0,16'h0,   1'b0,1'b0,16'h0,   1'b0,16'h0,16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1};
    vt[3]  = '{1'b0, 1'b0,1'b0,16'h0,   1'b0,1'b0,16'h0,   1'b0,16'h0,16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1};
    vt[4]  = '{1'b0, 1'b0,1'b0,16'h0,   1'b0,1'b0,16'h0,   1'b1,16'h0010,16'hBEEF, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,0};
    vt[5]  = '{1'b0, 1'b0,1'b0,16'h0,   1'b0,1'b0,16'h0,   1'b0,16'h0,16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,0};
    vt[6]  = '{1'b1, 1'b0,1'b0,16'h0,   1'b0,1'b0,16'h0,   1'b0,16'h0,16'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,0};
    vt[7]  = '{1'b0, 1'b1,1'b0,16'h0100,1'b1,1'b0,16'h0200,1'b0,16'h0,16'h0,    1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1};
    vt[8]  = '{1'b0, 1'b1,1'b0,16'h0101,1'b1,1'b0,16'h0200,1'b0,16'h0,16'h0,    1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2};
    vt[9]  = '{1'b0, 1'b1,1'b0,16'h0101,1'b1,1'b0,16'h0201,1'b0,16'h0,16'h0,    1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,3};
    vt[10] = '{1'b0, 1'b1,1'b0,16'h0102,1'b1,1'b0,16'h0201,1'b0,16'h0,16'h0,    1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4};
    vt[11] = '{1'b0, 1'b1,1'b0,16'h0102,1'b1,1'b1,16'h0300,1'b0,16'h0,16'h0,    1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4};
    vt[12] = '{1'b0, 1'b1,1'b0,16'h0102,1'b0,1'b0,16'h0,   1'b1,16'h0100,16'h1111, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3};
    vt[13] = '{1'b0, 1'b1,1'b0,16'h0102,1'b0,1'b0,16'h0,   1'b0,16'h0,16'h0,    1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4};

    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst) begin
        do_reset();
      end else begin
        cyc(vt[i].v0, vt[i].we0, vt[i].a0, 16'h1234, vt[i].v1, vt[i].we1, vt[i].a1, 16'h5678,
            vt[i].ack, vt[i].ra, vt[i].rd);
        chk($sformatf("v%0d_rdy0", i), cap_rdy0, vt[i].x_rdy0);
        chk($sformatf("v%0d_rdy1", i), cap_rdy1, vt[i].x_rdy1);
        chk($sformatf("v%0d_wr", i),   cap_wr,   vt[i].x_wr);
        chk($sformatf("v%0d_rd", i),   cap_rd,   vt[i].x_rd);
        chk($sformatf("v%0d_rv0", i),  cap_rv0,  vt[i].x_rv0);
        chk($sformatf("v%0d_rv1", i),  cap_rv1,  vt[i].x_rv1);
        chk($sformatf("v%0d_out", i),  cap_out,  vt[i].x_out);
      end
    end

    // Address hazard: r1 read of 0x0040 outstanding blocks r0 read and write.
    do_reset();
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("hz_rd_blocked", cap_rdy0, 0);
    cyc(1'b1, 1'b1, 16'h0040, 16'hAAAA, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("hz_wr_blocked", cap_rdy0, 0);
    cyc(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0040, 16'hCAFE);
    chk("hz_same_cycle_blocked", cap_rdy0, 0);
    chk("hz_ret_r1", cap_rv1, 1);
    chk("hz_ret_not_r0", cap_rv0, 0);
    cyc(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("hz_read_after_free", cap_rdy0, 1);

    // Orphan return is sticky until reset.
    do_reset();
    idle(1'b1, 16'h7777, 16'h1234);
    chk("orph_set", cap_orph, 1);
    chk("orph_no_rv", cap_rv0 | cap_rv1, 0);
    idle(1'b0, 16'h0, 16'h0);
    idle(1'b0, 16'h0, 16'h0);
    chk("orph_sticky", cap_orph, 1);
    do_reset();

    // Reset with reads outstanding discards them; late returns are orphans.
    cyc(1'b1, 1'b0, 16'h000A, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h000B, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("rs_two_out", cap_out, 2);
    do_reset();
    idle(1'b1, 16'h000A, 16'h5555);
    chk("rs_late_ret_orphan", cap_orph, 1);
    chk("rs_late_ret_no_rv", cap_rv0, 0);
    idle(1'b1, 16'h000B, 16'h6666);
    chk("rs_late_ret2_no_rv", cap_rv1, 0);

    // Randomized traffic with requests held until accepted.
    do_reset();
    for (int k = 0; k < 2; k++) p_v[k] = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic        ack;
      logic [15:0] ra;
      for (int k = 0; k < 2; k++) begin
        if (!p_v[k] && ($urandom_range(0, 9) < 6)) begin
          p_v[k]  = 1'b1;
          p_we[k] = ($urandom_range(0, 3) == 0);
          p_a[k]  = 16'h0020 + 16'($urandom_range(0, 7));
          p_d[k]  = 16'($urandom);
        end
      end
      ack = 1'b0; ra = 16'h0;
      if (m_addr.size() > 0 && $urandom_range(0, 9) < 4) begin
        ack = 1'b1;
        ra  = m_addr[$urandom_range(0, m_addr.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        ack = 1'b1;
        ra  = 16'h0020 + 16'($urandom_range(0, 15));
      end
      cyc(p_v[0], p_we[0], p_a[0], p_d[0], p_v[1], p_we[1], p_a[1], p_d[1],
          ack, ra, 16'($urandom));
      if (cap_rdy0) p_v[0] = 1'b0;
      if (cap_rdy1) p_v[1] = 1'b0;
      if (n % 500 == 499) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
